ik_swift_readback: RTL and testbench

IK_SWIFT_READBACK -- requirements
Module: ik_swift_readback

---
 rtl/ik_swift_pkg.sv | 29 ++
 rtl/ik_swift_readback_if.sv | 13 +
 rtl/ik_delta_snapshot.sv | 58 +++++
 rtl/ik_swift_readback.sv | 116 +++++++++++
 tb/tb_ik_swift_readback.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/ik_swift_pkg.sv
// Shared constants for the IK solver readback slave: sizing, byte address map
// and status bit positions.
package ik_swift_pkg;

    localparam int MAX_JOINT = 6;
    localparam int DW        = 36;

    localparam logic [7:0] STATUS       = 8'd0;
    localparam logic [7:0] ACK          = 8'd1;
    localparam logic [7:0] COUNT        = 8'd2;
    localparam logic [7:0] DELTA_BASE   = 8'd8;
    localparam logic [7:0] DELTA_STRIDE = 8'd8;
    localparam logic [2:0] MSB_OFFSET   = 3'd3;

    localparam int ST_READY   = 0;
    localparam int ST_OVERRUN = 1;
    localparam int ST_LOCKED  = 2;

    function automatic logic [7:0] pack_status(input logic locked, input logic overrun,
                                               input logic ready);
        logic [7:0] s;
        s              = 8'h00;
        s[ST_LOCKED]   = locked;
        s[ST_OVERRUN]  = overrun;
        s[ST_READY]    = ready;
        return s;
    endfunction

endpackage

// File: rtl/ik_swift_readback_if.sv
// Read-only byte bus between a host master and the readback slave.
interface ik_swift_readback_if;
    import ik_swift_pkg::*;

    logic       chipselect;
    logic       read;
    logic [7:0] address;
    logic [7:0] readdata;

    modport master (output chipselect, output read, output address, input readdata);
    modport slave  (input chipselect, input read, input address, output readdata);

endinterface

// File: rtl/ik_delta_snapshot.sv
// Snapshot buffer of MAX_JOINT solver deltas with a combinational byte read port;
// words are presented sign-extended to 40 bits, most significant byte at offset 3.
module ik_delta_snapshot #(
    parameter int MAX_JOINT = ik_swift_pkg::MAX_JOINT,
    parameter int DW        = ik_swift_pkg::DW
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_i,
    input  logic [MAX_JOINT*DW-1:0] delta_i,
    input  logic [4:0]              slot_i,
    input  logic [2:0]              off_i,
    output logic [7:0]              byte_o
);
    import ik_swift_pkg::*;

    logic [MAX_JOINT*DW-1:0] buf_q;
    logic [DW-1:0]           word_s;
    logic [39:0]             ext_s;

    // Buffer load on accepted capture; cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            buf_q <= '0;
        end else if (load_i) begin
            buf_q <= delta_i;
        end else begin
            buf_q <= buf_q;
        end
    end

    // Word select by slot; out-of-range slots read as zero.
    always_comb begin
        word_s = '0;
        for (int k = 0; k < MAX_JOINT; k++) begin
            if (slot_i == 5'(k)) begin
                word_s = buf_q[k*DW +: DW];
            end else begin
                word_s = word_s;
            end
        end
    end

    assign ext_s = {{(40-DW){word_s[DW-1]}}, word_s};

    // Byte lane select; offsets below MSB_OFFSET carry no data.
    always_comb begin
        case (off_i)
            3'd3:    byte_o = ext_s[39:32];
            3'd4:    byte_o = ext_s[31:24];
            3'd5:    byte_o = ext_s[23:16];
            3'd6:    byte_o = ext_s[15:8];
            3'd7:    byte_o = ext_s[7:0];
            default: byte_o = 8'h00;
        endcase
    end

endmodule

// File: rtl/ik_swift_readback.sv
// Readback slave for IK solver joint deltas: address decode, lock/ack/overrun
// control and capture counting around the snapshot buffer.
module ik_swift_readback #(
    parameter int MAX_JOINT = ik_swift_pkg::MAX_JOINT,
    parameter int DW        = ik_swift_pkg::DW
) (
    input  logic                    clk,
    input  logic                    reset,
    ik_swift_readback_if.slave      bus,
    input  logic                    delta_valid,
    input  logic [MAX_JOINT*DW-1:0] delta,
    output logic                    result_ready
);
    import ik_swift_pkg::*;

    logic       locked_q, locked_d;
    logic       overrun_q, overrun_d;
    logic       ready_q, ready_d;
    logic [7:0] count_q, count_d;
    logic [7:0] rdata_q, rdata_d;

    logic       access_s;
    logic       ack_s;
    logic       delta_hit_s;
    logic       capture_s;
    logic [7:0] rel_s;
    logic [4:0] slot_s;
    logic [2:0] off_s;
    logic [7:0] snap_byte_s;
    logic [7:0] status_s;

    assign access_s    = bus.chipselect && bus.read;
    assign rel_s       = bus.address - DELTA_BASE;
    assign slot_s      = rel_s[7:3];
    assign off_s       = rel_s[2:0];
    assign delta_hit_s = (bus.address >= DELTA_BASE) && (slot_s < 5'(MAX_JOINT))
                         && (off_s >= MSB_OFFSET);
    assign ack_s       = access_s && (bus.address == ACK);
    assign status_s    = pack_status(locked_q, overrun_q, ready_q);
    // An ack in the same cycle releases the lock before the capture is judged.
    assign capture_s   = delta_valid && (!locked_q || ack_s);

    ik_delta_snapshot #(
        .MAX_JOINT (MAX_JOINT),
        .DW        (DW)
    ) u_snapshot (
        .clk    (clk),
        .reset  (reset),
        .load_i (capture_s),
        .delta_i(delta),
        .slot_i (slot_s),
        .off_i  (off_s),
        .byte_o (snap_byte_s)
    );

    // Control flag and counter next-state.
    always_comb begin
        locked_d  = locked_q;
        overrun_d = overrun_q;
        ready_d   = ready_q;
        count_d   = count_q;
        if (ack_s) begin
            locked_d  = 1'b0;
            overrun_d = 1'b0;
            ready_d   = 1'b0;
        end else if (access_s && delta_hit_s) begin
            locked_d = 1'b1;
        end else begin
            locked_d = locked_q;
        end
        if (capture_s) begin
            ready_d = 1'b1;
            count_d = count_q + 8'd1;
        end else if (delta_valid) begin
            overrun_d = 1'b1;
        end else begin
            count_d = count_q;
        end
    end

    // Read data mux; values reflect state before this edge's updates.
    always_comb begin
        rdata_d = rdata_q;
        if (access_s) begin
            case (bus.address)
                STATUS:  rdata_d = status_s;
                ACK:     rdata_d = status_s;
                COUNT:   rdata_d = count_q;
                default: rdata_d = delta_hit_s ? snap_byte_s : 8'h00;
            endcase
        end else begin
            rdata_d = rdata_q;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            locked_q  <= 1'b0;
            overrun_q <= 1'b0;
            ready_q   <= 1'b0;
            count_q   <= 8'd0;
            rdata_q   <= 8'h00;
        end else begin
            locked_q  <= locked_d;
            overrun_q <= overrun_d;
            ready_q   <= ready_d;
            count_q   <= count_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus.readdata = rdata_q;
    assign result_ready = ready_q;

endmodule

// File: tb/tb_ik_swift_readback.sv
// Scoreboard bench for ik_swift_readback: directed scenarios then random traffic,
// expectations from an abstract register-map model.
module tb_ik_swift_readback;
    localparam int NJ = 6;
    localparam int W  = 36;

    logic            clk = 1'b1;
    logic            reset;
    logic            delta_valid;
    logic [NJ*W-1:0] delta;
    logic            result_ready;

    always #5 clk = ~clk;

    ik_swift_readback_if bus_if ();

    ik_swift_readback dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus_if.slave),
        .delta_valid (delta_valid),
        .delta       (delta),
        .result_ready(result_ready)
    );

    typedef struct packed {
        logic [7:0] rd;
        logic       rr;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    logic [W-1:0] m_buf[NJ];
    int           m_cnt;
    bit           m_lock, m_ovr, m_rr;

    function automatic logic [7:0] m_read(input int a);
        longint v;
        if (a == 0 || a == 1) return {5'd0, m_lock, m_ovr, m_rr};
        if (a == 2) return 8'(m_cnt);
        if (a >= 8 && a < 8 + 8*NJ && (a % 8) >= 3) begin
            v = longint'(signed'(m_buf[(a-8)/8]));
            return 8'((v >>> (8*(7 - (a % 8)))) & 64'd255);
        end
        return 8'h00;
    endfunction

    function automatic logic [NJ*W-1:0] rand_delta();
        logic [NJ*W-1:0] d;
        for (int k = 0; k < NJ; k++) begin
            d[k*W +: W] = {4'($urandom_range(0, 15)), 32'($urandom())};
        end
        return d;
    endfunction

    // One bus cycle: drive inputs, advance the model, queue expected readback.
    task automatic cyc(input bit cs, input bit rd, input int a, input bit dv,
                       input logic [NJ*W-1:0] d, input bit rst_n);
        bit         acc, ack, hit;
        logic [7:0] e;
        @(negedge clk);
        bus_if.chipselect = cs;
        bus_if.read       = rd;
        bus_if.address    = 8'(a);
        delta_valid       = dv;
        delta             = d;
        reset             = rst_n;
        if (!rst_n) begin
            for (int k = 0; k < NJ; k++) m_buf[k] = '0;
            m_cnt = 0; m_lock = 0; m_ovr = 0; m_rr = 0;
            sb_q.push_back('{rd: 8'h00, rr: 1'b0});
        end else begin
            acc = cs && rd;
            e   = acc ? m_read(a) : 8'h00;
            ack = acc && (a == 1);
            hit = acc && a >= 8 && a < 8 + 8*NJ && (a % 8) >= 3;
            if (ack) begin
                m_lock = 0; m_ovr = 0; m_rr = 0;
            end
            if (dv) begin
                if (!m_lock) begin
                    for (int k = 0; k < NJ; k++) m_buf[k] = d[k*W +: W];
                    m_cnt = (m_cnt + 1) % 256;
                    m_rr  = 1;
                end else begin
                    m_ovr = 1;
                end
            end
            if (hit) m_lock = 1;
            if (acc) sb_q.push_back('{rd: e, rr: m_rr});
        end
    endtask

    task automatic rd_at(input int a);
        cyc(1'b1, 1'b1, a, 1'b0, delta, 1'b1);
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 0, 1'b0, delta, 1'b1);
    endtask

    // Monitor: any cycle with an access or reset produces a checkable response.
    always begin
        bit   take;
        exp_t e;
        @(posedge clk);
        take = (bus_if.chipselect === 1'b1 && bus_if.read === 1'b1) || (reset === 1'b0);
        #2;
        if (take) begin
            if (sb_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL sb_underflow: response with no queued expectation at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                checks++;
                if (bus_if.readdata !== e.rd) begin
                    failures++;
                    $display("FAIL readdata: got %02h expected %02h at %0t", bus_if.readdata, e.rd, $time);
                end
                checks++;
                if (result_ready !== e.rr) begin
                    failures++;
                    $display("FAIL result_ready: got %0b expected %0b at %0t", result_ready, e.rr, $time);
                end
            end
        end
    end

    initial begin
        logic [NJ*W-1:0] d;
        int              a, r;
        bus_if.chipselect = 1'b0;
        bus_if.read       = 1'b0;
        bus_if.address    = 8'h00;
        delta_valid       = 1'b0;
        delta             = '0;
        reset             = 1'b0;

        // Reset and empty reads
        cyc(1'b0, 1'b0, 0, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b0, 0, 1'b0, '0, 1'b0);
        rd_at(0); rd_at(2); rd_at(11); rd_at(200);

        // Capture with known slot 0 and byte readback
        d = rand_delta();
        d[W-1:0] = 36'h8_1234_5678;
        cyc(1'b0, 1'b0, 0, 1'b1, d, 1'b1);
        idle();
        for (int i = 11; i <= 15; i++) rd_at(i);
        rd_at(0); rd_at(2);
        for (int i = 8; i < 64; i += 7) rd_at(i);

        // Dropped capture while locked
        rd_at(12);
        cyc(1'b0, 1'b0, 0, 1'b1, rand_delta(), 1'b1);
        rd_at(0); rd_at(11); rd_at(2);

        // Ack releases status
        rd_at(1); rd_at(0);

        // Read-first-delta-byte colliding with capture
        cyc(1'b1, 1'b1, 19, 1'b1, rand_delta(), 1'b1);
        rd_at(19); rd_at(0);

        // Ack colliding with capture
        cyc(1'b1, 1'b1, 1, 1'b1, rand_delta(), 1'b1);
        rd_at(0); rd_at(27); rd_at(28); rd_at(2);

        // Chipselect without read, read without chipselect
        cyc(1'b1, 1'b0, 1, 1'b0, delta, 1'b1);
        cyc(1'b0, 1'b1, 1, 1'b0, delta, 1'b1);
        rd_at(0);

        // Multi-cycle delta_valid
        rd_at(1);
        cyc(1'b0, 1'b0, 0, 1'b1, rand_delta(), 1'b1);
        cyc(1'b0, 1'b0, 0, 1'b1, rand_delta(), 1'b1);
        rd_at(2); rd_at(7*8 + 4); rd_at(44);

        // Count wrap then reset mid-lock
        cyc(1'b0, 1'b0, 0, 1'b0, delta, 1'b0);
        for (int i = 0; i < 256; i++) begin
            cyc(1'b0, 1'b0, 0, 1'b1, rand_delta(), 1'b1);
            rd_at(1);
        end
        rd_at(2);
        cyc(1'b0, 1'b0, 0, 1'b1, rand_delta(), 1'b1);
        rd_at(12);
        cyc(1'b0, 1'b0, 0, 1'b1, rand_delta(), 1'b1);
        cyc(1'b0, 1'b0, 0, 1'b0, delta, 1'b0);
        rd_at(0); rd_at(2); rd_at(12);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 9);
            if (r < 7)      a = $urandom_range(0, 63);
            else if (r < 9) a = $urandom_range(0, 2);
            else            a = $urandom_range(0, 255);
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, a,
                $urandom_range(0, 3) == 0, rand_delta(), $urandom_range(0, 99) != 0);
        end

        idle(); idle(); idle();
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected responses never observed, expected 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
